ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits and register specifiers at 5 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 EX_regdst, EX_alusrc, EX_memtoreg, EX_regwrite, EX_memread, EX_memwrite, EX_branch  in  1 each  control bits from the ID/EX register.
REQ-005 EX_aluop  in  2  00 add, 01 sub, 10 R-type by funct, 11 or.
REQ-006 EX_PC  in  32  PC+4 of the instruction in EX.
REQ-007 EX_Rt, EX_Rd  in  5 each  candidate destination registers.
REQ-008 EX_readda1, EX_readda2  in  32 each  register operands.
REQ-009 EX_byte_offset_or_imm  in  32  sign-extended immediate; bits [5:0] are funct.
REQ-010 mem_stall  in  1  MEM stage busy; hold all outputs.
REQ-011 ext_flush  in  1  external squash of the instruction currently in EX.
REQ-012 MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite  out  1 each  registered control.
REQ-013 MEM_aluresult  out  32; MEM_writedata  out  32 (registered EX_readda2); MEM_writereg  out  5.
REQ-014 MEM_zero  out  1; MEM_branch_taken  out  1 (PCSrc); MEM_branch_target  out  32.

Function
REQ-015 Operand B SHALL be EX_byte_offset_or_imm when EX_alusrc=1, else EX_readda2.
REQ-016 aluop 10 funct decode SHALL be: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1 or 0); any other funct SHALL produce add.
REQ-017 Add/sub SHALL wrap modulo 2^32 with no overflow exception.
REQ-018 Zero SHALL be 1 iff the 32-bit ALU result equals 0.
REQ-019 Branch target SHALL be EX_PC + (EX_byte_offset_or_imm << 2), truncated to 32 bits.
REQ-020 Write register SHALL be EX_Rd when EX_regdst=1, else EX_Rt.
REQ-021 Latency: every MEM_* output SHALL reflect the EX inputs sampled at the previous posedge (one cycle).
REQ-022 MEM_branch_taken SHALL be registered (EX_branch AND zero) of a non-squashed instruction.
REQ-023 Squash condition SHALL be ext_flush=1 OR MEM_branch_taken=1 at the sampling edge (instruction in EX is wrong-path).
REQ-024 On squash, MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite, MEM_branch_taken SHALL load 0; data outputs SHALL load normally.
REQ-025 When mem_stall=1 every output register SHALL hold its value; stall SHALL take priority over squash and over new capture.
REQ-026 A taken branch held by mem_stall SHALL keep MEM_branch_taken=1 until stall releases; the first unstalled edge SHALL then squash the EX instruction.
REQ-027 Two consecutive taken branches: the second SHALL be squashed by the first, so MEM_branch_taken SHALL never be 1 on two consecutive unstalled cycles.

Reset
REQ-028 rst=1 SHALL immediately (without clk) clear all outputs to 0, yielding a bubble in MEM.
REQ-029 Reset asserted mid-stall or mid-branch SHALL override both; first edge after deassertion SHALL capture EX inputs normally.

Structure
REQ-030 ALU opcode encodings, funct constants and aluop codes SHALL live in the shared pipeline package used by all stages.
REQ-031 The combinational ALU plus ALU-control decode SHALL be one sub-module, alu_unit; the stage register, squash and stall logic SHALL be in ex_mem_stage.

Verification
REQ-032 R-type add: readda1=5, readda2=7, aluop=10, funct=100000, regdst=1, Rd=3, regwrite=1 -> next edge MEM_aluresult=12, MEM_writereg=3, MEM_regwrite=1.
REQ-033 slt signed: readda1=0xFFFFFFFF, readda2=1, funct=101010 -> MEM_aluresult=1; swapped operands -> 0.
REQ-034 beq taken: EX_PC=0x100, imm=0xFFFFFFFC, readda1=readda2=9, aluop=01, branch=1 -> MEM_branch_taken=1, MEM_branch_target=0xF0; following instruction with memwrite=1 -> MEM_memwrite=0.
REQ-035 Stall: sw in EX, mem_stall=1 for 3 cycles with changing EX inputs -> outputs frozen 3 cycles, then follow EX inputs.
REQ-036 Reset mid-branch: MEM_branch_taken=1, assert rst between edges -> all outputs 0 before the next posedge.
REQ-037 ext_flush with lw in EX -> MEM_memread=0, MEM_regwrite=0 next cycle; MEM_aluresult still equals address.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline definitions: ALU control encodings, funct constants and the
// ALU-control decode helper used by the execute stage.
package ex_mem_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RLEN = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  typedef enum logic [5:0] {
    FUNCT_ADD = 6'b100000,
    FUNCT_SUB = 6'b100010,
    FUNCT_AND = 6'b100100,
    FUNCT_OR  = 6'b100101,
    FUNCT_SLT = 6'b101010
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // Unrecognised R-type funct codes fall back to add.
  function automatic alu_op_e decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_OR:  op = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_SLT: op = ALU_SLT;
          default:   op = ALU_ADD;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: ID/EX-side inputs, stage controls and MEM-side outputs.
interface ex_mem_if;
  import ex_mem_stage_pkg::*;

  logic             EX_regdst, EX_alusrc, EX_memtoreg, EX_regwrite;
  logic             EX_memread, EX_memwrite, EX_branch;
  logic [1:0]       EX_aluop;
  logic [XLEN-1:0]  EX_PC;
  logic [RLEN-1:0]  EX_Rt, EX_Rd;
  logic [XLEN-1:0]  EX_readda1, EX_readda2;
  logic [XLEN-1:0]  EX_byte_offset_or_imm;
  logic             mem_stall, ext_flush;

  logic             MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite;
  logic [XLEN-1:0]  MEM_aluresult, MEM_writedata;
  logic [RLEN-1:0]  MEM_writereg;
  logic             MEM_zero, MEM_branch_taken;
  logic [XLEN-1:0]  MEM_branch_target;

  modport master (
    output EX_regdst, EX_alusrc, EX_memtoreg, EX_regwrite, EX_memread, EX_memwrite,
           EX_branch, EX_aluop, EX_PC, EX_Rt, EX_Rd, EX_readda1, EX_readda2,
           EX_byte_offset_or_imm, mem_stall, ext_flush,
    input  MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite, MEM_aluresult,
           MEM_writedata, MEM_writereg, MEM_zero, MEM_branch_taken, MEM_branch_target
  );

  modport slave (
    input  EX_regdst, EX_alusrc, EX_memtoreg, EX_regwrite, EX_memread, EX_memwrite,
           EX_branch, EX_aluop, EX_PC, EX_Rt, EX_Rd, EX_readda1, EX_readda2,
           EX_byte_offset_or_imm, mem_stall, ext_flush,
    output MEM_memtoreg, MEM_regwrite, MEM_memread, MEM_memwrite, MEM_aluresult,
           MEM_writedata, MEM_writereg, MEM_zero, MEM_branch_taken, MEM_branch_target
  );
endinterface

// File: rtl/ex_mem_stage_alu_unit.sv
// Combinational ALU with its ALU-control decode; results wrap modulo 2^32.
module alu_unit
  import ex_mem_stage_pkg::*;
(
  input  logic [1:0]      aluop_i,
  input  logic [5:0]      funct_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);
  alu_op_e op;
  logic    slt;

  always_comb begin
    op  = decode_alu(aluop_i, funct_i);
    slt = $signed(a_i) < $signed(b_i);
    result_o = '0;
    case (op)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(XLEN-1){1'b0}}, slt};
      default: result_o = a_i + b_i;
    endcase
    zero_o = (result_o == '0);
  end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: ALU, branch resolution and the EX/MEM register with
// stall hold and wrong-path squash of control bits.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input logic   clk,
  input logic   rst,
  ex_mem_if.slave bus
);
  logic [XLEN-1:0] opb, alu_result;
  logic            alu_zero, squash;

  logic            memtoreg_d, regwrite_d, memread_d, memwrite_d, bt_d, zero_d;
  logic            memtoreg_q, regwrite_q, memread_q, memwrite_q, bt_q, zero_q;
  logic [XLEN-1:0] aluresult_d, writedata_d, target_d;
  logic [XLEN-1:0] aluresult_q, writedata_q, target_q;
  logic [RLEN-1:0] writereg_d, writereg_q;

  assign opb = bus.EX_alusrc ? bus.EX_byte_offset_or_imm : bus.EX_readda2;

  alu_unit u_alu (
    .aluop_i  (bus.EX_aluop),
    .funct_i  (bus.EX_byte_offset_or_imm[5:0]),
    .a_i      (bus.EX_readda1),
    .b_i      (opb),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // A taken branch already in MEM means the instruction now in EX is wrong-path.
  always_comb begin
    squash      = bus.ext_flush | bt_q;
    memtoreg_d  = bus.EX_memtoreg & ~squash;
    regwrite_d  = bus.EX_regwrite & ~squash;
    memread_d   = bus.EX_memread  & ~squash;
    memwrite_d  = bus.EX_memwrite & ~squash;
    bt_d        = bus.EX_branch & alu_zero & ~squash;
    zero_d      = alu_zero;
    aluresult_d = alu_result;
    writedata_d = bus.EX_readda2;
    writereg_d  = bus.EX_regdst ? bus.EX_Rd : bus.EX_Rt;
    target_d    = bus.EX_PC + {bus.EX_byte_offset_or_imm[XLEN-3:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memtoreg_q  <= 1'b0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      bt_q        <= 1'b0;
      zero_q      <= 1'b0;
      aluresult_q <= '0;
      writedata_q <= '0;
      writereg_q  <= '0;
      target_q    <= '0;
    end else if (!bus.mem_stall) begin
      memtoreg_q  <= memtoreg_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      bt_q        <= bt_d;
      zero_q      <= zero_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      writereg_q  <= writereg_d;
      target_q    <= target_d;
    end
  end

  assign bus.MEM_memtoreg      = memtoreg_q;
  assign bus.MEM_regwrite      = regwrite_q;
  assign bus.MEM_memread       = memread_q;
  assign bus.MEM_memwrite      = memwrite_q;
  assign bus.MEM_branch_taken  = bt_q;
  assign bus.MEM_zero          = zero_q;
  assign bus.MEM_aluresult     = aluresult_q;
  assign bus.MEM_writedata     = writedata_q;
  assign bus.MEM_writereg      = writereg_q;
  assign bus.MEM_branch_target = target_q;
endmodule
